// File: rtl/multi_timer_bank.sv
`timescale 1ns/1ps
// multi_timer_bank: NUM_CH independent H:M:S countdown timers sharing one button set and
// one 1 Hz tick. Buttons and the BCD display target the channel chosen by sel_ch.
module multi_timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int HOUR_MAX  = 23,
  parameter int ADD_A_MIN = 5,
  parameter int ADD_B_MIN = 10,
  parameter int RING_SECS = 10
) (
  input  logic                clk_1k,
  input  logic                rst_n,
  input  logic                tick_1hz,
  input  logic [CH_W-1:0]     sel_ch,
  input  logic                btn_h_inc,
  input  logic                btn_m_inc,
  input  logic                btn_s_inc,
  input  logic                btn_start,
  input  logic                btn_clear,
  input  logic                btn_ack,
  input  logic                btn_add_a,
  input  logic                btn_add_b,
  output logic [3:0]          tm_h_tens,
  output logic [3:0]          tm_h_ones,
  output logic [3:0]          tm_m_tens,
  output logic [3:0]          tm_m_ones,
  output logic [3:0]          tm_s_tens,
  output logic [3:0]          tm_s_ones,
  output logic [1:0]          disp_state,
  output logic [2*NUM_CH-1:0] ch_state,
  output logic [NUM_CH-1:0]   ring_mask,
  output logic                led_blink,
  output logic                piezo_out
);
  localparam int H_W     = $clog2(HOUR_MAX + 1);
  localparam int MAX_MIN = HOUR_MAX * 60 + 59;

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2, RINGING = 2'd3} state_t;
  typedef enum logic [3:0] {B_NONE, B_CLEAR, B_ACK, B_START, B_ADD_A, B_ADD_B, B_H, B_M, B_S} btn_t;
  typedef struct packed { logic [H_W-1:0] h; logic [5:0] m; logic [5:0] s; } hms_t;
  typedef struct packed { state_t st; logic [7:0] rc; hms_t t; } ch_t;

  ch_t    ch_q [NUM_CH];
  btn_t   btn;
  hms_t   shown;
  state_t shown_st;
  logic   any_ring;
  logic   pz_div;

  function automatic logic is_zero(hms_t v);
    return v == '0;
  endfunction

  function automatic hms_t dec_hms(hms_t v);
    hms_t r = v;
    if (v.s != 6'd0) r.s = v.s - 6'd1;
    else if (v.m != 6'd0) begin
      r.m = v.m - 6'd1;
      r.s = 6'd59;
    end else if (v.h != '0) begin
      r.h = v.h - H_W'(1);
      r.m = 6'd59;
      r.s = 6'd59;
    end
    return r;
  endfunction

  // Adds whole minutes with carry into hours; anything past HOUR_MAX:59 pins to HOUR_MAX:59:59.
  function automatic hms_t add_min(hms_t v, int n);
    hms_t r = v;
    int   tm;
    tm = int'(v.h) * 60 + int'(v.m) + n;
    if (tm > MAX_MIN) begin
      r.h = H_W'(HOUR_MAX);
      r.m = 6'd59;
      r.s = 6'd59;
    end else begin
      r.h = H_W'(tm / 60);
      r.m = 6'(tm % 60);
    end
    return r;
  endfunction

  // Tick effect is computed first; an honoured button on the selected channel then overrides it.
  function automatic ch_t step(ch_t c, logic tick, logic hit, btn_t b);
    ch_t  n = c;
    hms_t d = (tick && c.st == RUNNING) ? dec_hms(c.t) : c.t;
    if (tick) begin
      case (c.st)
        RUNNING: begin
          n.t = d;
          if (is_zero(d)) begin
            n.st = RINGING;
            n.rc = 8'(RING_SECS);
          end
        end
        RINGING: begin
          n.rc = c.rc - 8'd1;
          if (c.rc == 8'd1) n.st = IDLE;
        end
        default: ;
      endcase
    end
    if (hit) begin
      case (b)
        B_CLEAR: begin
          n.st = IDLE;
          n.rc = '0;
          n.t  = '0;
        end
        B_ACK: if (c.st == RINGING) begin
          n.st = IDLE;
          n.rc = '0;
          n.t  = c.t;
        end
        B_START: case (c.st)
          IDLE:    if (!is_zero(c.t)) n.st = RUNNING;
          RUNNING: begin
            n.st = PAUSED;
            n.t  = c.t;
            n.rc = c.rc;
          end
          PAUSED:  n.st = RUNNING;
          default: ;
        endcase
        B_ADD_A, B_ADD_B: if (c.st != RINGING) begin
          n.st = c.st;
          n.rc = c.rc;
          n.t  = add_min(d, (b == B_ADD_A) ? ADD_A_MIN : ADD_B_MIN);
        end
        B_H, B_M, B_S: if (c.st == IDLE || c.st == PAUSED) begin
          if (b == B_H) n.t.h = (c.t.h == H_W'(HOUR_MAX)) ? '0 : c.t.h + H_W'(1);
          if (b == B_M) n.t.m = (c.t.m == 6'd59) ? 6'd0 : c.t.m + 6'd1;
          if (b == B_S) n.t.s = (c.t.s == 6'd59) ? 6'd0 : c.t.s + 6'd1;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  always_comb begin
    // NOTE: default assigned first so every path drives btn and no latch is inferred.
    btn = B_NONE;
    if      (btn_clear) btn = B_CLEAR;
    else if (btn_ack)   btn = B_ACK;
    else if (btn_start) btn = B_START;
    else if (btn_add_a) btn = B_ADD_A;
    else if (btn_add_b) btn = B_ADD_B;
    else if (btn_h_inc) btn = B_H;
    else if (btn_m_inc) btn = B_M;
    else if (btn_s_inc) btn = B_S;
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the channel array is plain flops rather than RAM, so every entry is reset.
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else begin
      // NOTE: non-blocking so every channel steps from its own pre-edge value.
      for (int k = 0; k < NUM_CH; k++)
        ch_q[k] <= step(ch_q[k], tick_1hz, sel_ch == CH_W'(k), btn);
    end
  end

  always_comb begin
    ch_state  = '0;
    ring_mask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_state[2*k +: 2] = ch_q[k].st;
      ring_mask[k]       = (ch_q[k].st == RINGING);
    end
  end

  // Out-of-range selections blank the display.
  always_comb begin
    shown    = '0;
    shown_st = IDLE;
    if (int'(sel_ch) < NUM_CH) begin
      shown    = ch_q[sel_ch].t;
      shown_st = ch_q[sel_ch].st;
    end
  end

  assign tm_h_tens  = 4'(shown.h / 10);
  assign tm_h_ones  = 4'(shown.h % 10);
  assign tm_m_tens  = 4'(shown.m / 10);
  assign tm_m_ones  = 4'(shown.m % 10);
  assign tm_s_tens  = 4'(shown.s / 10);
  assign tm_s_ones  = 4'(shown.s % 10);
  assign disp_state = shown_st;
  assign any_ring   = |ring_mask;

  // pz_div halves the toggle rate so piezo_out changes every second clk_1k cycle.
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      led_blink <= 1'b0;
      pz_div    <= 1'b0;
      piezo_out <= 1'b0;
    end else if (!any_ring) begin
      led_blink <= 1'b0;
      pz_div    <= 1'b0;
      piezo_out <= 1'b0;
    end else begin
      if (tick_1hz) led_blink <= ~led_blink;
      pz_div <= ~pz_div;
      if (pz_div) piezo_out <= ~piezo_out;
    end
  end
endmodule

// File: tb/tb_multi_timer_bank.sv
`timescale 1ns/1ps
// Bench for multi_timer_bank: directed vector table, hand sequences for ringing, piezo and
// reset, then random traffic compared against a model that keeps each timer as total seconds.
module tb_multi_timer_bank;
  localparam int NUM_CH = 4, CH_W = 2, HOUR_MAX = 23, ADD_A = 5, ADD_B = 10, RING_SECS = 10;
  localparam int MAX_SECS = HOUR_MAX * 3600 + 59 * 60 + 59;
  localparam logic [7:0] CLR = 8'h80, ACK = 8'h40, START = 8'h20, ADDA = 8'h10,
                         ADDB = 8'h08, HI = 8'h04, MI = 8'h02, SI = 8'h01;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, RING = 3;

  logic clk_1k = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
  logic [CH_W-1:0] sel_ch = '0;
  logic btn_h_inc = 0, btn_m_inc = 0, btn_s_inc = 0, btn_start = 0;
  logic btn_clear = 0, btn_ack = 0, btn_add_a = 0, btn_add_b = 0;
  logic [3:0] tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones;
  logic [1:0] disp_state;
  logic [2*NUM_CH-1:0] ch_state;
  logic [NUM_CH-1:0] ring_mask;
  logic led_blink, piezo_out;
  logic [23:0] disp;

  int   n_checks = 0, n_fail = 0;
  int   m_secs[NUM_CH], m_st[NUM_CH], m_rc[NUM_CH];
  logic m_led, m_prev_any;
  int   rsel;

  typedef struct { int rep; logic [7:0] b; logic t; int sel; logic [23:0] disp; int st; logic [3:0] mask; } vec_t;
  vec_t vecs[$];

  always #5 clk_1k = ~clk_1k;
  assign disp = {tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones};

  multi_timer_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W), .HOUR_MAX(HOUR_MAX), .ADD_A_MIN(ADD_A),
                     .ADD_B_MIN(ADD_B), .RING_SECS(RING_SECS)) dut (
    .clk_1k(clk_1k), .rst_n(rst_n), .tick_1hz(tick_1hz), .sel_ch(sel_ch),
    .btn_h_inc(btn_h_inc), .btn_m_inc(btn_m_inc), .btn_s_inc(btn_s_inc), .btn_start(btn_start),
    .btn_clear(btn_clear), .btn_ack(btn_ack), .btn_add_a(btn_add_a), .btn_add_b(btn_add_b),
    .tm_h_tens(tm_h_tens), .tm_h_ones(tm_h_ones), .tm_m_tens(tm_m_tens), .tm_m_ones(tm_m_ones),
    .tm_s_tens(tm_s_tens), .tm_s_ones(tm_s_ones), .disp_state(disp_state), .ch_state(ch_state),
    .ring_mask(ring_mask), .led_blink(led_blink), .piezo_out(piezo_out));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bcd_of(int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic model_any();
    logic a = 1'b0;
    for (int k = 0; k < NUM_CH; k++) if (m_st[k] == RING) a = 1'b1;
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_secs[k] = 0;
      m_st[k]   = IDLE;
      m_rc[k]   = 0;
    end
    m_led      = 1'b0;
    m_prev_any = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic t, input int s);
    logic any0;
    any0 = model_any();
    for (int k = 0; k < NUM_CH; k++) begin
      int top, hh, mm, ss, base;
      bit used;
      top  = -1;
      used = 1'b0;
      if (k == s) for (int i = 7; i >= 0; i--) if (b[i] && top < 0) top = i;
      case (top)
        7: begin m_secs[k] = 0; m_st[k] = IDLE; m_rc[k] = 0; used = 1'b1; end
        6: if (m_st[k] == RING) begin m_st[k] = IDLE; m_rc[k] = 0; used = 1'b1; end
        5: begin
          if (m_st[k] == IDLE) begin
            if (m_secs[k] != 0) m_st[k] = RUN;
            used = 1'b1;
          end else if (m_st[k] == RUN) begin
            m_st[k] = PAUSE; used = 1'b1;
          end else if (m_st[k] == PAUSE) begin
            m_st[k] = RUN; used = 1'b1;
          end
        end
        4, 3: if (m_st[k] != RING) begin
          base = (m_st[k] == RUN && t) ? m_secs[k] - 1 : m_secs[k];
          base = base + ((top == 4) ? ADD_A : ADD_B) * 60;
          m_secs[k] = (base > MAX_SECS) ? MAX_SECS : base;
          used = 1'b1;
        end
        2, 1, 0: if (m_st[k] == IDLE || m_st[k] == PAUSE) begin
          hh = m_secs[k] / 3600;
          mm = (m_secs[k] / 60) % 60;
          ss = m_secs[k] % 60;
          if (top == 2) hh = (hh == HOUR_MAX) ? 0 : hh + 1;
          if (top == 1) mm = (mm + 1) % 60;
          if (top == 0) ss = (ss + 1) % 60;
          m_secs[k] = hh * 3600 + mm * 60 + ss;
          used = 1'b1;
        end
        default: ;
      endcase
      if (!used && t) begin
        if (m_st[k] == RUN) begin
          m_secs[k]--;
          if (m_secs[k] == 0) begin m_st[k] = RING; m_rc[k] = RING_SECS; end
        end else if (m_st[k] == RING) begin
          m_rc[k]--;
          if (m_rc[k] == 0) m_st[k] = IDLE;
        end
      end
    end
    m_led      = any0 ? (t ? ~m_led : m_led) : 1'b0;
    m_prev_any = any0;
  endtask

  task automatic compare_model();
    int s;
    logic [2*NUM_CH-1:0] e_st;
    logic [NUM_CH-1:0]   e_mask;
    s = int'(sel_ch);
    for (int k = 0; k < NUM_CH; k++) begin
      e_st[2*k +: 2] = 2'(m_st[k]);
      e_mask[k]      = (m_st[k] == RING);
    end
    check("m_disp", disp, bcd_of(m_secs[s]));
    check("m_disp_state", disp_state, m_st[s]);
    check("m_ch_state", ch_state, e_st);
    check("m_ring_mask", ring_mask, e_mask);
    check("m_led", led_blink, m_led);
    if (!m_prev_any && !model_any()) check("m_piezo_quiet", piezo_out, 0);
  endtask

  task automatic apply(input logic [7:0] b, input logic t, input int s);
    sel_ch = CH_W'(s);
    {btn_clear, btn_ack, btn_start, btn_add_a, btn_add_b, btn_h_inc, btn_m_inc, btn_s_inc} = b;
    tick_1hz = t;
    @(posedge clk_1k);
    #1;
    {btn_clear, btn_ack, btn_start, btn_add_a, btn_add_b, btn_h_inc, btn_m_inc, btn_s_inc} = '0;
    tick_1hz = 1'b0;
    model_step(b, t, s);
    compare_model();
  endtask

  task automatic add_vec(input int rep, input logic [7:0] b, input logic t, input int sel,
                         input logic [23:0] d, input int st, input logic [3:0] mask);
    vec_t v;
    v.rep = rep; v.b = b; v.t = t; v.sel = sel; v.disp = d; v.st = st; v.mask = mask;
    vecs.push_back(v);
  endtask

  // Ch0 has just started ringing: check piezo cadence, led toggling and the auto-silence timeout.
  task automatic ring_sequence();
    logic prev, d, d_prev;
    int toggles, bad;
    toggles = 0; bad = 0; d_prev = 1'b0;
    prev = piezo_out;
    for (int c = 0; c < 12; c++) begin
      apply(8'h00, 1'b0, 0);
      d    = (piezo_out != prev);
      prev = piezo_out;
      if (c > 0 && d == d_prev) bad++;
      if (d) toggles++;
      d_prev = d;
    end
    check("piezo_every_2", bad, 0);
    check("piezo_toggles", toggles, 6);
    apply(8'h00, 1'b1, 0);
    check("led_first_tick", led_blink, 1);
    repeat (RING_SECS - 2) apply(8'h00, 1'b1, 0);
    check("ring_hold_state", disp_state, RING);
    apply(8'h00, 1'b1, 0);
    check("ring_timeout_state", disp_state, IDLE);
    check("ring_timeout_mask", ring_mask, 4'b0000);
    apply(8'h00, 1'b0, 0);
    check("silent_led", led_blink, 0);
    check("silent_piezo", piezo_out, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_1k);
    #1;
    check("rst_disp", disp, 24'h000000);
    check("rst_ch_state", ch_state, 8'h00);
    check("rst_mask", ring_mask, 4'b0000);
    check("rst_led", led_blink, 0);
    check("rst_piezo", piezo_out, 0);
    rst_n = 1'b1;

    add_vec(5,  SI,    0, 0, 24'h000005, IDLE, 4'b0000);
    add_vec(1,  START, 0, 0, 24'h000005, RUN,  4'b0000);
    add_vec(4,  8'h00, 1, 0, 24'h000001, RUN,  4'b0000);
    add_vec(1,  8'h00, 1, 0, 24'h000000, RING, 4'b0001);
    add_vec(10, SI,    0, 0, 24'h000010, IDLE, 4'b0000);
    add_vec(1,  START, 0, 0, 24'h000010, RUN,  4'b0000);
    add_vec(2,  8'h00, 1, 0, 24'h000008, RUN,  4'b0000);
    add_vec(1,  START, 0, 0, 24'h000008, PAUSE, 4'b0000);
    add_vec(4,  8'h00, 1, 0, 24'h000008, PAUSE, 4'b0000);
    add_vec(1,  START, 0, 0, 24'h000008, RUN,  4'b0000);
    add_vec(1,  8'h00, 1, 0, 24'h000007, RUN,  4'b0000);
    add_vec(1,  CLR,   1, 0, 24'h000000, IDLE, 4'b0000);
    add_vec(23, HI,    0, 3, 24'h230000, IDLE, 4'b0000);
    add_vec(58, MI,    0, 3, 24'h235800, IDLE, 4'b0000);
    add_vec(1,  ADDB,  0, 3, 24'h235959, IDLE, 4'b0000);
    add_vec(1,  CLR,   0, 3, 24'h000000, IDLE, 4'b0000);
    add_vec(1,  SI,    0, 3, 24'h000001, IDLE, 4'b0000);
    add_vec(1,  START, 0, 3, 24'h000001, RUN,  4'b0000);
    add_vec(1,  8'h00, 1, 3, 24'h000000, RING, 4'b1000);
    add_vec(1,  ADDA,  0, 3, 24'h000000, RING, 4'b1000);
    add_vec(1,  ADDA,  1, 3, 24'h000000, RING, 4'b1000);
    add_vec(1,  ACK,   1, 3, 24'h000000, IDLE, 4'b0000);
    add_vec(1,  SI,    0, 0, 24'h000001, IDLE, 4'b0000);
    add_vec(1,  START, 0, 0, 24'h000001, RUN,  4'b0000);
    add_vec(1,  ADDA,  1, 0, 24'h000500, RUN,  4'b0000);
    add_vec(1,  START, 1, 0, 24'h000500, PAUSE, 4'b0000);
    add_vec(1,  START, 1, 0, 24'h000500, RUN,  4'b0000);
    add_vec(1,  8'h00, 1, 0, 24'h000459, RUN,  4'b0000);
    add_vec(1,  CLR,   0, 0, 24'h000000, IDLE, 4'b0000);
    add_vec(1,  HI,    0, 0, 24'h010000, IDLE, 4'b0000);
    add_vec(59, MI,    0, 0, 24'h015900, IDLE, 4'b0000);
    add_vec(1,  MI,    0, 0, 24'h010000, IDLE, 4'b0000);
    add_vec(1,  ADDA | SI, 0, 0, 24'h010500, IDLE, 4'b0000);
    add_vec(1,  CLR | START, 0, 0, 24'h000000, IDLE, 4'b0000);
    add_vec(1,  START, 0, 0, 24'h000000, IDLE, 4'b0000);
    add_vec(24, HI,    0, 0, 24'h000000, IDLE, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].rep) apply(vecs[i].b, vecs[i].t, vecs[i].sel);
      check($sformatf("vec%0d_disp", i), disp, vecs[i].disp);
      check($sformatf("vec%0d_state", i), disp_state, vecs[i].st);
      check($sformatf("vec%0d_mask", i), ring_mask, vecs[i].mask);
      if (i == 3) ring_sequence();
    end

    // Two channels counting at once while the selection moves between them.
    repeat (20) apply(SI, 1'b0, 1);
    apply(START, 1'b0, 1);
    repeat (2) apply(8'h00, 1'b1, 2);
    repeat (3) apply(SI, 1'b0, 2);
    apply(START, 1'b0, 2);
    repeat (3) apply(8'h00, 1'b1, 2);
    check("ch2_ringing", disp_state, RING);
    check("ch2_mask", ring_mask, 4'b0100);
    apply(8'h00, 1'b0, 1);
    check("ch1_disp", disp, 24'h000015);
    check("ch1_state", disp_state, RUN);
    check("all_states", ch_state, 8'h34);
    apply(CLR, 1'b0, 1);
    apply(CLR, 1'b0, 2);

    // Asynchronous reset in the middle of a countdown and a ring.
    repeat (4) apply(SI, 1'b0, 0);
    apply(START, 1'b0, 0);
    apply(8'h00, 1'b1, 0);
    repeat (2) apply(SI, 1'b0, 3);
    apply(START, 1'b0, 3);
    repeat (2) apply(8'h00, 1'b1, 3);
    check("pre_reset_mask", ring_mask, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_disp", disp, 24'h000000);
    check("async_rst_state", ch_state, 8'h00);
    check("async_rst_mask", ring_mask, 4'b0000);
    check("async_rst_led", led_blink, 0);
    check("async_rst_piezo", piezo_out, 0);
    model_reset();
    @(posedge clk_1k);
    #1 rst_n = 1'b1;

    rsel = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] b;
      int r;
      b = 8'h00;
      if ($urandom_range(0, 9) == 0) rsel = $urandom_range(0, NUM_CH - 1);
      if ($urandom_range(0, 99) < 30) begin
        r = $urandom_range(0, 19);
        if (r <= 5)       b = SI;
        else if (r <= 8)  b = MI;
        else if (r == 9)  b = HI;
        else if (r <= 12) b = START;
        else if (r <= 14) b = ADDA;
        else if (r == 15) b = ADDB;
        else if (r <= 17) b = ACK;
        else if (r == 18) b = CLR;
        else              b = 8'($urandom);
      end
      apply(b, ($urandom_range(0, 3) == 0), rsel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_timer_bank.md
Name: multi_timer_bank

Overview:
- Parametrised successor to the single-channel countdown timer controller.
- Holds NUM_CH independent H:M:S countdown channels. Every running channel counts down on the shared 1 Hz tick, including channels not on display.
- One button set edits and controls the channel chosen by sel_ch. Adds pause/resume, configurable add-minute presets, an auto-silence ring timeout and a per-channel ring mask.
- Sits beside the clock core. Feeds the display mux, RGB/LED and piezo drivers.

Parameters:
- NUM_CH, 4: number of timer channels (2..8).
- CH_W, 2: width of sel_ch, equal to ceil(log2(NUM_CH)).
- HOUR_MAX, 23: highest settable or saturated hour value.
- ADD_A_MIN, 5: minutes added by btn_add_a.
- ADD_B_MIN, 10: minutes added by btn_add_b.
- RING_SECS, 10: tick count after which ringing self-silences (1..255).

Ports:
- clk_1k  in  1  1 kHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-cycle pulse, once per second.
- sel_ch  in  CH_W  channel targeted by buttons and shown on display.
- btn_h_inc, btn_m_inc, btn_s_inc  in  1 each  debounced one-cycle increment pulses.
- btn_start  in  1  start / pause / resume pulse.
- btn_clear  in  1  clear selected channel.
- btn_ack  in  1  silence ringing on selected channel.
- btn_add_a, btn_add_b  in  1 each  add-minute preset pulses.
- tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones  out  4 each  BCD time of selected channel.
- disp_state  out  2  state of selected channel.
- ch_state  out  2*NUM_CH  all channel states; channel k occupies bits [2k+1:2k].
- ring_mask  out  NUM_CH  bit k set while channel k is RINGING.
- led_blink  out  1  ringing indicator.
- piezo_out  out  1  buzzer drive.

Behaviour:
- Reset (async, rst_n=0):
  - every channel is 00:00:00, IDLE, ring counter 0.
  - led_blink=0, piezo_out=0, ring_mask=0.
- State encoding: IDLE=0, RUNNING=1, PAUSED=2, RINGING=3.
- Timing: registers update on the clk_1k edge sampling a pulse. Display outputs and disp_state are combinational from the sel_ch-indexed registers, so new values are visible one cycle after the pulse.
- Field ranges: h 0..HOUR_MAX, m 0..59, s 0..59.
- Increment buttons:
  - honoured only in IDLE or PAUSED.
  - each field wraps to 0 independently with no carry (59→0, HOUR_MAX→0).
- btn_start:
  - IDLE with nonzero time → RUNNING. IDLE with 00:00:00 → ignored.
  - RUNNING → PAUSED; PAUSED → RUNNING.
  - RINGING → ignored.
- tick_1hz, applied to every channel in parallel:
  - RUNNING: decrement by 1 s with borrow (00:01:00→00:00:59; 01:00:00→00:59:59).
  - RUNNING reaching 00:00:00 on a tick → RINGING in the same cycle, ring counter loaded with RING_SECS.
  - RINGING: ring counter decrements on each tick; when it reaches 0 → IDLE.
  - IDLE and PAUSED: tick ignored.
- btn_ack in RINGING → IDLE, time stays 00:00:00; otherwise ignored.
- btn_clear, any state → IDLE, 00:00:00, ring counter 0.
- btn_add_a / btn_add_b:
  - honoured in IDLE, RUNNING and PAUSED; ignored in RINGING.
  - adds N minutes with carry into hours.
  - saturates at HOUR_MAX:59:59.
  - does not change state.
- Button priority within one cycle on the selected channel: clear > ack > start > add_a > add_b > h_inc > m_inc > s_inc. Only the highest-priority pulse acts.
- Button and tick in the same cycle on the selected channel:
  - clear / ack: the tick is discarded.
  - start that changes state (run, pause, resume): no decrement that cycle.
  - add in RUNNING: result = value − 1 s + N min, saturated. If the decrement alone would reach zero, the add wins and the channel stays RUNNING.
- sel_ch changing mid-operation affects nothing except which channel the buttons and display target.
- sel_ch ≥ NUM_CH: buttons ignored, display all zero, disp_state=0.
- led_blink:
  - toggles on each tick_1hz while any ring_mask bit is set.
  - forced to 0 in the cycle after ring_mask becomes 0.
- piezo_out:
  - 250 Hz square wave (toggle every 2 clk_1k cycles) while ring_mask[sel_ch]=1 or any ring_mask bit is set.
  - otherwise held 0.
- Reset asserted mid-countdown returns all channels to the reset values immediately.

Test Plan:
- Reset, sel_ch=0, 5×btn_s_inc, btn_start, 5 ticks → ch0 reaches 00:00:00, disp_state=3, ring_mask=0001, piezo toggles every 2 cycles. After RING_SECS more ticks → IDLE, piezo_out=0, led_blink=0.
- ch1 set 00:00:20 and started; sel_ch=2; 2 ticks; ch2 set 00:00:03 and started; 3 ticks → ch2 RINGING, ring_mask=0100. sel_ch=1 displays 00:00:15, RUNNING.
- ch0 00:00:10 RUNNING; 2 ticks; btn_start → PAUSED at 00:00:08; 4 ticks → still 00:00:08. btn_start, 1 tick → 00:00:07.
- ch3 set 23:58:00; btn_add_b → 23:59:59 (saturated). btn_add_a in RINGING → ignored. btn_ack in RINGING → IDLE, ring_mask bit clear.
- ch0 RUNNING at 00:00:01; btn_add_a in the same cycle as tick → 00:05:00 RUNNING, no ring. btn_start with tick on a running channel → PAUSED, value unchanged.
- 59×btn_m_inc then 1 more → m wraps to 00, hours unchanged. btn_clear with btn_start together → IDLE 00:00:00. rst_n low mid-run → all outputs at reset values asynchronously.
